// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer: datapath constants,
// operation encodings, controller states and a bit-reversal helper.
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    // Operation encodings as presented by the ALU op decoder; 101-111 are illegal.
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Mirror a WIDTH-bit word end for end (bit 0 <-> bit WIDTH-1).
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_left.sv
// Combinational logarithmic left barrel shifter; zero-fills from the LSB.
module barrel_left #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] stage [SHW+1];

    assign stage[0] = data;

    // Stage s shifts by 2**s when amount bit s is set.
    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int STEP = 1 << s;
        assign stage[s+1] = amount[s] ? (stage[s] << STEP) : stage[s];
    end

    assign result = stage[SHW];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller time-sharing one left barrel shifter
// for SLL, SRL, SRA, ROL and ROR with a start/busy/done handshake.
// Optional feature macro: SHIFT_CARRY_EN adds the registered 'carry' output
// holding the last bit shifted out.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int SHW   = shift_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SHIFT_CARRY_EN
    ,
    output logic             carry
`endif
);

    state_e           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] operand_q;
    logic [SHW-1:0]   amount_q;
    logic [WIDTH-1:0] acc;

    logic             is_right;
    logic             is_rot;
    logic             legal;
    logic             need_pass2;
    logic [SHW-1:0]   amt_eff;

    logic [WIDTH-1:0] sh_data;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_out;
    logic             rev_out;
    logic [WIDTH-1:0] pass_val;
    logic [WIDTH-1:0] res_nxt;

    // Decode the latched operation; ROR by n is performed as ROL by 16-n.
    always_comb begin
        is_right   = (op_q == OP_SRL) || (op_q == OP_SRA);
        is_rot     = (op_q == OP_ROL) || (op_q == OP_ROR);
        legal      = (op_q <= OP_ROR);
        need_pass2 = (op_q == OP_SRA) || (is_rot && (amount_q != '0));
        case (op_q)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL: amt_eff = amount_q;
            OP_ROR:                         amt_eff = SHW'(0) - amount_q;
            default:                        amt_eff = '0;
        endcase
    end

    // Steer the shared shifter. Right shifts wrap the left shifter in
    // bit reversals; pass 2 builds the SRA sign mask or the wrapped-around
    // half of a rotate.
    always_comb begin
        sh_data = '0;
        sh_amt  = '0;
        rev_out = 1'b0;
        case (state)
            PASS1: begin
                sh_data = is_right ? bit_reverse(operand_q) : operand_q;
                sh_amt  = amt_eff;
                rev_out = is_right;
            end
            PASS2: begin
                if (op_q == OP_SRA) begin
                    sh_data = '1;
                    sh_amt  = amount_q;
                end else begin
                    sh_data = bit_reverse(operand_q);
                    sh_amt  = SHW'(0) - amt_eff;
                end
                rev_out = 1'b1;
            end
            default: begin
                sh_data = '0;
                sh_amt  = '0;
                rev_out = 1'b0;
            end
        endcase
    end

    barrel_left #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (sh_data),
        .amount (sh_amt),
        .result (sh_out)
    );

    // Un-reverse right-shift results and form the value committed at done.
    always_comb begin
        pass_val = rev_out ? bit_reverse(sh_out) : sh_out;
        res_nxt  = legal ? pass_val : operand_q;
        if (state == PASS2) begin
            if (op_q == OP_SRA) begin
                res_nxt = acc | (operand_q[WIDTH-1] ? ~pass_val : '0);
            end else begin
                res_nxt = acc | pass_val;
            end
        end
    end

`ifdef SHIFT_CARRY_EN
    logic carry_nxt;

    // Last bit shifted out, derived from the latched operand or final result.
    always_comb begin
        carry_nxt = 1'b0;
        if (legal && (amount_q != '0)) begin
            case (op_q)
                OP_SLL:         carry_nxt = operand_q[SHW'(0) - amount_q];
                OP_SRL, OP_SRA: carry_nxt = operand_q[amount_q - SHW'(1)];
                OP_ROL:         carry_nxt = res_nxt[0];
                OP_ROR:         carry_nxt = res_nxt[WIDTH-1];
                default:        carry_nxt = 1'b0;
            endcase
        end
    end
`endif

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            operand_q <= '0;
            amount_q  <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
`ifdef SHIFT_CARRY_EN
            carry     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        operand_q <= operand;
                        amount_q  <= amount;
                        busy      <= 1'b1;
                        state     <= PASS1;
                    end
                end
                PASS1: begin
                    acc <= pass_val;
                    if (need_pass2) begin
                        state <= PASS2;
                    end else begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= res_nxt;
`ifdef SHIFT_CARRY_EN
                        carry  <= carry_nxt;
`endif
                        state  <= DONE;
                    end
                end
                PASS2: begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= res_nxt;
`ifdef SHIFT_CARRY_EN
                    carry  <= carry_nxt;
`endif
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table-driven operations with a
// scoreboard queue, plus hand sequences for start-while-busy and mid-op reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] operand;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] result;
`ifdef SHIFT_CARRY_EN
    logic        carry;
`endif

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(16), .SHW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result)
`ifdef SHIFT_CARRY_EN
        ,
        .carry   (carry)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] operand;
        logic [3:0]  amount;
        logic [15:0] res;
        int          lat;
        logic        cy;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t sbq [$];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        vec_t e;
        int   cyc;
        int   busy_cnt;
        logic got;
        @(negedge clk);
        start = 1'b1; op = v.op; operand = v.operand; amount = v.amount;
        sbq.push_back(v);
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); operand = 16'($urandom); amount = 4'($urandom);
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 8) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        got = done;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            e = sbq.pop_front();
            check({tag, " result"}, 32'(result), 32'(e.res));
            check({tag, " latency"}, 32'(cyc), 32'(e.lat));
            check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(e.lat - 1));
            check({tag, " busy_at_done"}, 32'(busy), 32'd0);
`ifdef SHIFT_CARRY_EN
            check({tag, " carry"}, 32'(carry), 32'(e.cy));
`endif
            @(negedge clk);
            check({tag, " done_pulse"}, 32'(done), 32'd0);
            check({tag, " result_hold"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ndone;
        logic [15:0] cap;
        vec_t e;
        vec_t v;

        //            op       operand   amt  result   lat carry
        vecs[0]  = '{3'b000, 16'h00F1, 4'd4,  16'h0F10, 2, 1'b0};
        vecs[1]  = '{3'b010, 16'h8010, 4'd4,  16'hF801, 3, 1'b0};
        vecs[2]  = '{3'b100, 16'h1234, 4'd4,  16'h4123, 3, 1'b0};
        vecs[3]  = '{3'b011, 16'h8001, 4'd1,  16'h0003, 3, 1'b1};
        vecs[4]  = '{3'b011, 16'hABCD, 4'd0,  16'hABCD, 2, 1'b0};
        vecs[5]  = '{3'b001, 16'h8000, 4'd15, 16'h0001, 2, 1'b0};
        vecs[6]  = '{3'b111, 16'h5A5A, 4'd3,  16'h5A5A, 2, 1'b0};
        vecs[7]  = '{3'b000, 16'h8001, 4'd1,  16'h0002, 2, 1'b1};
        vecs[8]  = '{3'b001, 16'h0003, 4'd1,  16'h0001, 2, 1'b1};
        vecs[9]  = '{3'b010, 16'h7FF0, 4'd4,  16'h07FF, 3, 1'b0};
        vecs[10] = '{3'b100, 16'h0001, 4'd1,  16'h8000, 3, 1'b1};
        vecs[11] = '{3'b011, 16'h1234, 4'd15, 16'h091A, 3, 1'b0};
        vecs[12] = '{3'b000, 16'hFFFF, 4'd15, 16'h8000, 2, 1'b1};
        vecs[13] = '{3'b010, 16'h8000, 4'd15, 16'hFFFF, 3, 1'b0};
        vecs[14] = '{3'b101, 16'h1234, 4'd4,  16'h1234, 2, 1'b0};
        vecs[15] = '{3'b000, 16'h1234, 4'd0,  16'h1234, 2, 1'b0};
        vecs[16] = '{3'b100, 16'hABCD, 4'd0,  16'hABCD, 2, 1'b0};

        rst = 1'b1; start = 1'b0; op = '0; operand = '0; amount = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
`ifdef SHIFT_CARRY_EN
        check("reset carry", 32'(carry), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start re-asserted while busy must not launch a second operation.
        @(negedge clk);
        start = 1'b1; op = 3'b010; operand = 16'h8010; amount = 4'd4;
        v = '{3'b010, 16'h8010, 4'd4, 16'hF801, 3, 1'b0};
        sbq.push_back(v);
        @(negedge clk);
        op = 3'b000; operand = 16'hFFFF; amount = 4'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; cap = '0;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                ndone++;
                cap = result;
            end
            @(negedge clk);
        end
        check("busy_ignore done_count", 32'(ndone), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("busy_ignore result", 32'(cap), 32'(e.res));
        end
        check("busy_ignore result_hold", 32'(result), 32'h0000_F801);

        // Reset asserted in PASS2 of an SRA discards the operation.
        @(negedge clk);
        start = 1'b1; op = 3'b010; operand = 16'h8010; amount = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("after_reset no_done", 32'(ndone), 32'd0);
        check("after_reset busy", 32'(busy), 32'd0);
        run_op(vecs[0], "post_reset_sll");

        check("scoreboard empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
